// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, address-width helper and reset-value selectors for reg_file_mp
package regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 32;
  localparam int RST_ZERO = 0;
  localparam int RST_INDEX = 1;
  function automatic int aw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits; issue sets, any write clears, set beats clear
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int NWRITE = 1,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWRITE-1:0] wr_en,
  input  logic [NWRITE*AW-1:0] wr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [NREGS-1:0]  busy_vec
);
  logic [NREGS-1:0] set, clr;
  // decode this cycle's issue and writeback addresses into set/clear masks; register 0 is never marked
  always_comb begin
    clr = '0;
    set = '0;
    for (int j = 0; j < NWRITE; j++)
      if (wr_en[j]) clr[wr_addr[j*AW +: AW]] = 1'b1;
    if (iss_en) set[iss_addr] = 1'b1;
    set[0] = 1'b0;
  end
  // apply clears first so a same-cycle issue to the same register keeps it busy
  always_ff @(posedge clk or posedge rst)
    if (rst) busy_vec <= '0;
    else busy_vec <= (busy_vec & ~clr) | set;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with busy scoreboard; REGFILE_BYPASS_EN adds write-to-read forwarding
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = 2,
  parameter int NWRITE = 1,
  parameter int RESET_INDEX = RST_INDEX,
  localparam int AW = aw_of(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  output logic [NREGS-1:0]       busy_vec
);
  logic [XLEN-1:0] regs [NREGS];
  reg_scoreboard #(.NREGS(NREGS), .NWRITE(NWRITE), .AW(AW)) u_sb (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .iss_en(iss_en),
    .iss_addr(iss_addr),
    .busy_vec(busy_vec)
  );
  // data array: later write ports overwrite earlier ones, register 0 is never written
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < NREGS; i++) regs[i] <= (RESET_INDEX == RST_INDEX) ? XLEN'(i) : '0;
    else
      for (int j = 0; j < NWRITE; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] != '0) regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
  // combinational read ports, optionally forwarding same-cycle writes in port priority order
  always_comb begin
    for (int k = 0; k < NREAD; k++) begin
      rd_data[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
      rd_busy[k] = busy_vec[rd_addr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWRITE; j++)
        if (!rst && wr_en[j] && rd_addr[k*AW +: AW] != '0 && wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW]) begin
          rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
          rd_busy[k] = iss_en && iss_addr == rd_addr[k*AW +: AW];
        end
`endif
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: randomized and directed checks of reg_file_mp against an array-based reference model
module tb_reg_file_mp;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int NWRITE = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NREAD*AW-1:0] rd_addr = '0;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0] rd_busy;
  logic [NWRITE-1:0] wr_en = '0;
  logic [NWRITE*AW-1:0] wr_addr = '0;
  logic [NWRITE*XLEN-1:0] wr_data = '0;
  logic iss_en = 1'b0;
  logic [AW-1:0] iss_addr = '0;
  logic [NREGS-1:0] busy_vec;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] m [NREGS];
  bit mb [NREGS];

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE), .RESET_INDEX(1)) dut (
    .clk(clk),
    .rst(rst),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_busy(rd_busy),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .iss_en(iss_en),
    .iss_addr(iss_addr),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m[i] = XLEN'(i);
      mb[i] = 1'b0;
    end
  endtask

  task automatic apply_model();
    for (int j = 0; j < NWRITE; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] != 0) m[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
    for (int j = 0; j < NWRITE; j++)
      if (wr_en[j]) mb[wr_addr[j*AW +: AW]] = 1'b0;
    if (iss_en && iss_addr != 0) mb[iss_addr] = 1'b1;
  endtask

  function automatic logic [XLEN-1:0] exp_data(input int a);
    logic [XLEN-1:0] v;
    v = m[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NWRITE; j++)
      if (!rst && wr_en[j] && a != 0 && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*XLEN +: XLEN];
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input int a);
    logic b;
    b = mb[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NWRITE; j++)
      if (!rst && wr_en[j] && a != 0 && int'(wr_addr[j*AW +: AW]) == a) b = iss_en && int'(iss_addr) == a;
`endif
    return b;
  endfunction

  function automatic logic [NREGS-1:0] exp_vec();
    logic [NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = mb[i];
    return v;
  endfunction

  task automatic idle();
    wr_en = '0;
    iss_en = 1'b0;
  endtask

  task automatic tick();
    if (!rst) apply_model();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    rd_addr = {5'd5, 5'd0};
    #1;
    model_reset();
    checks++;
    if (rd_data !== {32'd5, 32'd0}) begin
      errors++;
      $display("FAIL reset_rd_data got %h exp %h", rd_data, {32'd5, 32'd0});
    end
    checks++;
    if (busy_vec !== '0 || rd_busy !== '0) begin
      errors++;
      $display("FAIL reset_busy got vec %h rd_busy %b exp 0", busy_vec, rd_busy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_x0();
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd0};
    wr_data = {32'd0, 32'hDEADBEEF};
    iss_en = 1'b1;
    iss_addr = 5'd0;
    tick();
    idle();
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_data[31:0] !== 32'd0) begin
      errors++;
      $display("FAIL x0_read got %h exp 0", rd_data[31:0]);
    end
    checks++;
    if (busy_vec[0] !== 1'b0) begin
      errors++;
      $display("FAIL x0_busy got %b exp 0", busy_vec[0]);
    end
  endtask

  task automatic test_collision();
    wr_en = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {32'h22, 32'h11};
    tick();
    idle();
    rd_addr = {5'd7, 5'd7};
    #1;
    checks++;
    if (rd_data !== {32'h22, 32'h22}) begin
      errors++;
      $display("FAIL collision got %h exp %h", rd_data, {32'h22, 32'h22});
    end
  endtask

  task automatic test_scoreboard();
    rd_addr = {5'd0, 5'd3};
    iss_en = 1'b1;
    iss_addr = 5'd3;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_issue_cycle got %b exp 0", rd_busy[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_busy_after_issue got %b exp 1", rd_busy[0]);
    end
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd3};
    wr_data = {32'd0, 32'hAB};
    iss_en = 1'b1;
    iss_addr = 5'd3;
    tick();
    idle();
    #1;
    checks++;
    if (busy_vec[3] !== 1'b1 || rd_data[31:0] !== 32'hAB) begin
      errors++;
      $display("FAIL sb_set_wins got busy %b data %h exp busy 1 data ab", busy_vec[3], rd_data[31:0]);
    end
    wr_en = 2'b10;
    wr_addr = {5'd3, 5'd0};
    wr_data = {32'hCD, 32'd0};
    tick();
    idle();
    #1;
    checks++;
    if (busy_vec[3] !== 1'b0 || rd_data[31:0] !== 32'hCD) begin
      errors++;
      $display("FAIL sb_clear got busy %b data %h exp busy 0 data cd", busy_vec[3], rd_data[31:0]);
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] want;
    wr_en = 2'b01;
    wr_addr = {5'd0, 5'd9};
    wr_data = {32'd0, 32'h55};
    rd_addr = {5'd9, 5'd9};
`ifdef REGFILE_BYPASS_EN
    want = 32'h55;
`else
    want = 32'd9;
`endif
    #1;
    checks++;
    if (rd_data !== {want, want}) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h exp %h", rd_data, {want, want});
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data !== {32'h55, 32'h55}) begin
      errors++;
      $display("FAIL bypass_next_cycle got %h exp %h", rd_data, {32'h55, 32'h55});
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < NWRITE; j++) begin
        wr_en[j] = 1'($urandom_range(0, 1));
        wr_addr[j*AW +: AW] = AW'($urandom_range(0, 15));
        wr_data[j*XLEN +: XLEN] = $urandom;
      end
      for (int k = 0; k < NREAD; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
      iss_en = 1'($urandom_range(0, 1));
      iss_addr = AW'($urandom_range(0, 15));
      #1;
      for (int k = 0; k < NREAD; k++) begin
        checks++;
        if (rd_data[k*XLEN +: XLEN] !== exp_data(int'(rd_addr[k*AW +: AW]))) begin
          errors++;
          $display("FAIL rand_data cyc %0d port %0d addr %0d got %h exp %h", c, k, rd_addr[k*AW +: AW],
                   rd_data[k*XLEN +: XLEN], exp_data(int'(rd_addr[k*AW +: AW])));
        end
        checks++;
        if (rd_busy[k] !== exp_busy(int'(rd_addr[k*AW +: AW]))) begin
          errors++;
          $display("FAIL rand_busy cyc %0d port %0d addr %0d got %b exp %b", c, k, rd_addr[k*AW +: AW],
                   rd_busy[k], exp_busy(int'(rd_addr[k*AW +: AW])));
        end
      end
      checks++;
      if (busy_vec !== exp_vec()) begin
        errors++;
        $display("FAIL rand_vec cyc %0d got %h exp %h", c, busy_vec, exp_vec());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_activity();
    wr_en = 2'b11;
    wr_addr = {5'd12, 5'd4};
    wr_data = {32'hAAAA, 32'hBBBB};
    iss_en = 1'b1;
    iss_addr = 5'd12;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle();
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (busy_vec !== '0) begin
      errors++;
      $display("FAIL rst_act_busy got %h exp 0", busy_vec);
    end
    for (int a = 0; a < NREGS; a += 2) begin
      rd_addr = {AW'(a + 1), AW'(a)};
      #1;
      checks++;
      if (rd_data !== {m[a+1], m[a]}) begin
        errors++;
        $display("FAIL rst_act_data addr %0d got %h exp %h", a, rd_data, {m[a+1], m[a]});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_x0();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_random();
    test_reset_activity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file with an integrated busy scoreboard, the next-generation replacement for the single-cycle core's 2R/1W register file. It provides NREAD combinational read ports and NWRITE synchronous write ports with fixed priority, hardwires register 0 to zero, and tracks which registers have an outstanding producer so the pipelined core can stall or forward. It sits between decode/issue, which reads operands and marks destinations busy, and writeback, which writes results and clears busy.

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of registers; power of two, at least 2. AW = log2(NREGS).
- NREAD, 2: number of read ports, 1..4.
- NWRITE, 1: number of write ports, 1..2. When two writes target the same register, the higher-indexed port wins.
- RESET_INDEX, 1: 1 means register i resets to i (register 0 to 0); 0 means all registers reset to 0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NREAD*AW  read addresses, packed; port k occupies [k*AW +: AW].
- rd_data  out  NREAD*XLEN  read data, packed the same way.
- rd_busy  out  NREAD  busy flag of each addressed register.
- wr_en  in  NWRITE  write enables.
- wr_addr  in  NWRITE*AW  write addresses.
- wr_data  in  NWRITE*XLEN  write data.
- iss_en  in  1  mark iss_addr busy (a new producer has been issued).
- iss_addr  in  AW  destination register being issued.
- busy_vec  out  NREGS  full scoreboard, for debug and hazard units.

## Operation
- Storage: NREGS x XLEN flops. Writes happen on the rising edge of clk when wr_en[j]=1 and wr_addr[j]!=0.
- Register 0 always reads 0, cannot be written, and is never busy. iss_en with iss_addr=0 is ignored.
- Write priority: if ports 0 and 1 target the same nonzero address in one cycle, wr_data[1] is stored.
- Scoreboard: one busy bit per register.
  - iss_en sets busy[iss_addr] at the clock edge.
  - Any enabled write to address a clears busy[a] at the clock edge.
  - If a set and a clear hit the same address in the same cycle, the set wins and the bit stays 1, because a newer producer now owns it.
- Reads are combinational: rd_data[k] = reg[rd_addr[k]]; rd_busy[k] = busy[rd_addr[k]].
- Multiple read ports may address the same register; each returns the same value.

## Timing
- Reset is asynchronous and takes effect immediately.
  - Registers load their reset values (set by RESET_INDEX).
  - All busy bits go to 0; busy_vec = 0.
  - rd_data reflects the reset values combinationally, and rd_busy = 0.
  - Reset asserted mid-operation discards all pending writes and issues in that cycle.
- Write-to-read latency without bypass is 1 cycle: data written at edge N is visible on rd_data after edge N.
- Issue-to-busy latency is 1 cycle. rd_busy in the issuing cycle reflects the old state.
- No handshake is used: writes and issues are accepted every cycle and the block never stalls.

## Configuration
- REGFILE_BYPASS_EN defined: a read whose address matches an enabled same-cycle write to a nonzero address returns that wr_data combinationally, with the highest-priority write winning. In the same case rd_busy[k] reads 0 unless iss_en targets the same address that cycle.
- REGFILE_BYPASS_EN undefined: reads return stored state only, which gives the 1-cycle latency above. Read-during-write returns the old value.

## Structure
- Shared package regfile_pkg contains:
  - default XLEN and NREGS;
  - the AW derivation function (clog2);
  - reset-value selection constants for RESET_INDEX.
- Sub-module reg_scoreboard holds the NREGS busy bits with set/clear/priority logic and exposes busy_vec. The data array and read muxes stay in reg_file_mp.

## Test plan
- Reset with RESET_INDEX=1: assert rst mid-cycle with no clock edge; rd_addr={5,0} gives rd_data={5,0} immediately, and busy_vec=0.
- Write x0: wr_en=1, wr_addr=0, wr_data=0xDEADBEEF; after the edge, reading address 0 returns 0 and busy_vec[0]=0.
- Dual-write collision (NWRITE=2): both ports write address 7 with 0x11 on port 0 and 0x22 on port 1; after the edge, reading 7 returns 0x22.
- Scoreboard: issue to address 3, and one cycle later rd_busy=1. Then in the same cycle write 3 with 0xAB and issue 3 again; after the edge busy[3]=1 and rd_data=0xAB. Write 3 once more and busy[3]=0.
- Bypass, built both ways: in one cycle write address 9 with 0x55 and read address 9. With REGFILE_BYPASS_EN the read returns 0x55 that cycle; without it, the read returns 9 that cycle and 0x55 the next.
- Reset during activity: pulse rst while wr_en=1 and iss_en=1; no write or busy bit survives, and all registers hold their reset values.
